// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg
// Shared encodings for the fetch-stage PC generator.
//   - next-PC source codes as driven on pc_src_in
//   - FSM state codes (RUN / HOLD / FAULT)
//   - redirect priorities used when merging a buffered redirect
//   - alignment mask for branch-target checking and epc/trap masking
// Optional feature macro: RVC_EN (2-byte alignment instead of 4-byte).
package pc_gen_pkg;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_EPC    = 2'b10;
  localparam logic [1:0] PC_SRC_TRAP   = 2'b11;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  // Larger value wins; equal priority lets the newer redirect replace the older.
  localparam logic [1:0] PRIO_SEQ    = 2'd0;
  localparam logic [1:0] PRIO_BRANCH = 2'd1;
  localparam logic [1:0] PRIO_EPC    = 2'd2;
  localparam logic [1:0] PRIO_TRAP   = 2'd3;

  // Low address bits that must be zero for a legal instruction address.
`ifdef RVC_EN
  localparam logic [1:0] ALIGN_LSB_MASK = 2'b01;
`else
  localparam logic [1:0] ALIGN_LSB_MASK = 2'b11;
`endif

endpackage

// File: rtl/pc_align_check.sv
// pc_align_check
// Combinational alignment helper for the PC generator.
//   target_lsbs   in  : low two bits of the branch/jump target
//   epc           in  : mret return address
//   trap_address  in  : trap vector address
//   misaligned    out : branch target violates instruction alignment
//   epc_masked    out : epc with the alignment bits forced to zero
//   trap_masked   out : trap vector with the alignment bits forced to zero
// Alignment is 4-byte by default, 2-byte when RVC_EN is defined (see pc_gen_pkg).
module pc_align_check
  import pc_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      target_lsbs,
  input  logic [XLEN-1:0] epc,
  input  logic [XLEN-1:0] trap_address,
  output logic            misaligned,
  output logic [XLEN-1:0] epc_masked,
  output logic [XLEN-1:0] trap_masked
);

  assign misaligned  = |(target_lsbs & ALIGN_LSB_MASK);
  // epc and trap vectors are trusted sources: they are masked, never faulted.
  assign epc_masked  = {epc[XLEN-1:2], epc[1:0] & ~ALIGN_LSB_MASK};
  assign trap_masked = {trap_address[XLEN-1:2], trap_address[1:0] & ~ALIGN_LSB_MASK};

endmodule

// File: rtl/pc_gen_unit.sv
// pc_gen_unit
// Registered program-counter generator for the RV32I fetch stage.
// Optional feature macro: RVC_EN (2-byte alignment, +2 step for compressed instrs).
// Ports:
//   clk_in                      in  : clock
//   rst_in                      in  : synchronous active-low reset
//   pc_src_in                   in  : 00 seq, 01 branch/jump, 10 mret, 11 trap
//   branch_taken_in             in  : qualifies branch source
//   iaddr_in / epc_in / trap_address_in in : redirect targets
//   ahb_ready_in                in  : fetch port ready (0 = stall)
//   instr_compressed_in         in  : current instruction is 16-bit (RVC_EN only)
//   pc_out / iaddr_out          out : registered fetch PC
//   fetch_valid_out             out : fetch request valid (low in reset and FAULT)
//   pc_plus_4_out               out : pc_out + 4 (link value)
//   pc_mux_out                  out : value pc_out takes on the next accepted edge
//   redirect_pending_out        out : a stalled redirect is buffered
//   misaligned_instr_logic_out  out : one-cycle misaligned branch fault pulse
//   misaligned_addr_out         out : faulting branch target
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [1:0]      pc_src_in,
  input  logic            branch_taken_in,
  input  logic [XLEN-1:0] iaddr_in,
  input  logic [XLEN-1:0] epc_in,
  input  logic [XLEN-1:0] trap_address_in,
  input  logic            ahb_ready_in,
  input  logic            instr_compressed_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] iaddr_out,
  output logic            fetch_valid_out,
  output logic [XLEN-1:0] pc_plus_4_out,
  output logic [XLEN-1:0] pc_mux_out,
  output logic            redirect_pending_out,
  output logic            misaligned_instr_logic_out,
  output logic [XLEN-1:0] misaligned_addr_out
);

  logic [1:0]      state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] pend_pc_reg, pend_pc_next;
  logic [1:0]      pend_prio_reg, pend_prio_next;
  logic            fetch_valid_reg;
  logic            mis_pulse_reg, mis_pulse_next;
  logic [XLEN-1:0] mis_addr_reg, mis_addr_next;

  logic [XLEN-1:0] seq_inc, seq_pc, in_pc, hold_pc, epc_masked, trap_masked;
  logic [1:0]      in_prio, hold_prio;
  logic            in_redirect, in_misaligned, branch_misaligned, take_new;

  pc_align_check #(.XLEN(XLEN)) u_align (
    .target_lsbs  (iaddr_in[1:0]),
    .epc          (epc_in),
    .trap_address (trap_address_in),
    .misaligned   (branch_misaligned),
    .epc_masked   (epc_masked),
    .trap_masked  (trap_masked)
  );

`ifdef RVC_EN
  assign seq_inc = instr_compressed_in ? XLEN'(2) : XLEN'(4);
`else
  logic unused_compressed;
  assign unused_compressed = instr_compressed_in;
  assign seq_inc = XLEN'(4);
`endif

  assign seq_pc        = pc_reg + seq_inc;
  assign pc_plus_4_out = pc_reg + XLEN'(4);

  // Decode this cycle's request into target, priority and legality.
  always_comb begin
    in_pc         = seq_pc;
    in_prio       = PRIO_SEQ;
    in_redirect   = 1'b0;
    in_misaligned = 1'b0;
    case (pc_src_in)
      PC_SRC_TRAP: begin
        in_pc       = trap_masked;
        in_prio     = PRIO_TRAP;
        in_redirect = 1'b1;
      end
      PC_SRC_EPC: begin
        in_pc       = epc_masked;
        in_prio     = PRIO_EPC;
        in_redirect = 1'b1;
      end
      PC_SRC_BRANCH: begin
        if (branch_taken_in) begin
          in_pc         = iaddr_in;
          in_prio       = PRIO_BRANCH;
          in_redirect   = ~branch_misaligned;
          in_misaligned = branch_misaligned;
        end
      end
      default: ;
    endcase
  end

  // Merge a buffered redirect with the current one; sequential never displaces it.
  assign take_new  = in_redirect && (in_prio >= pend_prio_reg);
  assign hold_pc   = take_new ? in_pc   : pend_pc_reg;
  assign hold_prio = take_new ? in_prio : pend_prio_reg;

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    pend_pc_next   = pend_pc_reg;
    pend_prio_next = pend_prio_reg;
    mis_pulse_next = 1'b0;
    mis_addr_next  = mis_addr_reg;
    pc_mux_out     = pc_reg;
    case (state_reg)
      ST_RUN: begin
        pc_mux_out = in_misaligned ? pc_reg : in_pc;
        if (in_misaligned) begin
          state_next     = ST_FAULT;
          mis_pulse_next = 1'b1;
          mis_addr_next  = iaddr_in;
        end else if (ahb_ready_in) begin
          pc_next = in_pc;
        end else if (in_redirect) begin
          pend_pc_next   = in_pc;
          pend_prio_next = in_prio;
          state_next     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        pc_mux_out = in_misaligned ? pc_reg : hold_pc;
        if (in_misaligned) begin
          state_next     = ST_FAULT;
          mis_pulse_next = 1'b1;
          mis_addr_next  = iaddr_in;
        end else if (ahb_ready_in) begin
          pc_next    = hold_pc;
          state_next = ST_RUN;
        end else begin
          pend_pc_next   = hold_pc;
          pend_prio_next = hold_prio;
        end
      end
      ST_FAULT: begin
        // Only the trap redirect leaves FAULT, even while the fetch port stalls.
        if (pc_src_in == PC_SRC_TRAP) begin
          pc_mux_out = trap_masked;
          pc_next    = trap_masked;
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_reg       <= ST_RUN;
      pc_reg          <= RESET_VECTOR;
      pend_pc_reg     <= '0;
      pend_prio_reg   <= PRIO_SEQ;
      fetch_valid_reg <= 1'b0;
      mis_pulse_reg   <= 1'b0;
      mis_addr_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      pend_pc_reg     <= pend_pc_next;
      pend_prio_reg   <= pend_prio_next;
      fetch_valid_reg <= (state_next != ST_FAULT);
      mis_pulse_reg   <= mis_pulse_next;
      mis_addr_reg    <= mis_addr_next;
    end
  end

  assign pc_out                     = pc_reg;
  assign iaddr_out                  = pc_reg;
  assign fetch_valid_out            = fetch_valid_reg;
  assign redirect_pending_out       = (state_reg == ST_HOLD);
  assign misaligned_instr_logic_out = mis_pulse_reg;
  assign misaligned_addr_out        = mis_addr_reg;

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb_pc_gen_unit
// Self-checking bench for pc_gen_unit: directed vector table, a few hand
// sequences for multi-cycle corners, then randomized traffic against a
// behavioural model of the PC rules.
module tb_pc_gen_unit;

  localparam logic [31:0] RV = 32'h0000_0080;
`ifdef RVC_EN
  localparam logic [31:0] ALIGN = 32'd2;
`else
  localparam logic [31:0] ALIGN = 32'd4;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [1:0]  pc_src_in;
  logic        branch_taken_in;
  logic [31:0] iaddr_in, epc_in, trap_address_in;
  logic        ahb_ready_in;
  logic        instr_compressed_in;
  logic [31:0] pc_out, iaddr_out, pc_plus_4_out, pc_mux_out, misaligned_addr_out;
  logic        fetch_valid_out, redirect_pending_out, misaligned_instr_logic_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  pc_gen_unit #(.XLEN(32), .RESET_VECTOR(RV)) dut (
    .clk_in                     (clk_in),
    .rst_in                     (rst_in),
    .pc_src_in                  (pc_src_in),
    .branch_taken_in            (branch_taken_in),
    .iaddr_in                   (iaddr_in),
    .epc_in                     (epc_in),
    .trap_address_in            (trap_address_in),
    .ahb_ready_in               (ahb_ready_in),
    .instr_compressed_in        (instr_compressed_in),
    .pc_out                     (pc_out),
    .iaddr_out                  (iaddr_out),
    .fetch_valid_out            (fetch_valid_out),
    .pc_plus_4_out              (pc_plus_4_out),
    .pc_mux_out                 (pc_mux_out),
    .redirect_pending_out       (redirect_pending_out),
    .misaligned_instr_logic_out (misaligned_instr_logic_out),
    .misaligned_addr_out        (misaligned_addr_out)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  src;
    logic        taken;
    logic [31:0] iaddr;
    logic [31:0] epc;
    logic [31:0] trap;
    logic        ready;
    logic [31:0] exp_pc;
    logic        exp_fv;
    logic        exp_pend;
    logic        exp_mis;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(input logic r, input logic [1:0] s, input logic t,
                              input logic [31:0] ia, input logic [31:0] ep,
                              input logic [31:0] tr, input logic rdy,
                              input logic [31:0] xpc, input logic xfv,
                              input logic xpend, input logic xmis);
    vec_t v;
    v.rst = r; v.src = s; v.taken = t; v.iaddr = ia; v.epc = ep; v.trap = tr;
    v.ready = rdy; v.exp_pc = xpc; v.exp_fv = xfv; v.exp_pend = xpend; v.exp_mis = xmis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] s, input logic t,
                       input logic [31:0] ia, input logic [31:0] ep,
                       input logic [31:0] tr, input logic rdy, input logic comp);
    rst_in = r; pc_src_in = s; branch_taken_in = t; iaddr_in = ia;
    epc_in = ep; trap_address_in = tr; ahb_ready_in = rdy; instr_compressed_in = comp;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [31:0] pc;
    int          prio;
  } red_t;

  red_t        m_q[$];
  logic [31:0] m_pc = RV;
  logic        m_fault = 1'b0;
  logic        m_fv = 1'b0;
  logic        m_mis = 1'b0;
  logic [31:0] m_maddr = 32'h0;

  function automatic logic [31:0] seq_step();
`ifdef RVC_EN
    return instr_compressed_in ? 32'd2 : 32'd4;
`else
    return 32'd4;
`endif
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int          prio;
    logic [31:0] tgt;
    red_t        win;
    red_t        nr;
    if (!rst_in) begin
      m_pc = RV; m_fault = 1'b0; m_fv = 1'b0; m_mis = 1'b0; m_maddr = 32'h0;
      m_q.delete();
    end else begin
      m_mis = 1'b0;
      prio  = 0;
      tgt   = m_pc + seq_step();
      if (pc_src_in == 2'd3) begin
        prio = 3; tgt = trap_address_in - (trap_address_in % ALIGN);
      end else if (pc_src_in == 2'd2) begin
        prio = 2; tgt = epc_in - (epc_in % ALIGN);
      end else if (pc_src_in == 2'd1 && branch_taken_in) begin
        prio = 1; tgt = iaddr_in;
      end
      if (m_fault) begin
        if (prio == 3) begin
          m_pc = tgt; m_fault = 1'b0;
        end
      end else if (prio == 1 && (iaddr_in % ALIGN) != 0) begin
        m_fault = 1'b1; m_mis = 1'b1; m_maddr = iaddr_in;
        m_q.delete();
      end else if (m_q.size() != 0) begin
        win = m_q[0];
        if (prio > 0 && prio >= win.prio) begin
          win.pc = tgt; win.prio = prio;
        end
        if (ahb_ready_in) begin
          m_pc = win.pc;
          m_q.delete();
        end else begin
          m_q[0] = win;
        end
      end else if (ahb_ready_in) begin
        m_pc = tgt;
      end else if (prio > 0) begin
        nr.pc = tgt; nr.prio = prio;
        m_q.push_back(nr);
      end
      m_fv = !m_fault;
    end
  endtask

  initial begin
    drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

`ifndef RVC_EN
    //            rst src taken iaddr          epc            trap           rdy  exp_pc        fv pend mis
    tbl[0]  = mk(0, 2'd0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h80,       0, 0, 0);
    tbl[1]  = mk(0, 2'd0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h80,       0, 0, 0);
    tbl[2]  = mk(1, 2'd0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h84,       1, 0, 0);
    tbl[3]  = mk(1, 2'd0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h88,       1, 0, 0);
    tbl[4]  = mk(1, 2'd3, 0, 32'h0,        32'h0,        32'h1000,     1, 32'h1000,     1, 0, 0);
    tbl[5]  = mk(1, 2'd1, 1, 32'h2000,     32'h0,        32'h0,        1, 32'h2000,     1, 0, 0);
    tbl[6]  = mk(1, 2'd1, 0, 32'h9000,     32'h0,        32'h0,        1, 32'h2004,     1, 0, 0);
    tbl[7]  = mk(1, 2'd3, 0, 32'h0,        32'h0,        32'h3000,     1, 32'h3000,     1, 0, 0);
    tbl[8]  = mk(1, 2'd2, 0, 32'h0,        32'hACBEFC5D, 32'h0,        0, 32'h3000,     1, 1, 0);
    tbl[9]  = mk(1, 2'd1, 1, 32'h4000,     32'h0,        32'h0,        0, 32'h3000,     1, 1, 0);
    tbl[10] = mk(1, 2'd0, 0, 32'h0,        32'h0,        32'h0,        1, 32'hACBEFC5C, 1, 0, 0);
    tbl[11] = mk(1, 2'd1, 1, 32'h56789ABE, 32'h0,        32'h0,        1, 32'hACBEFC5C, 0, 0, 1);
    tbl[12] = mk(1, 2'd0, 0, 32'h0,        32'h0,        32'h0,        1, 32'hACBEFC5C, 0, 0, 0);
    tbl[13] = mk(1, 2'd2, 0, 32'h0,        32'h7000,     32'h0,        1, 32'hACBEFC5C, 0, 0, 0);
    tbl[14] = mk(1, 2'd3, 0, 32'h0,        32'h0,        32'h11223344, 0, 32'h11223344, 1, 0, 0);
    tbl[15] = mk(1, 2'd3, 0, 32'h0,        32'h0,        32'hFFFFFFFF, 1, 32'hFFFFFFFC, 1, 0, 0);
    tbl[16] = mk(1, 2'd0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h0,        1, 0, 0);
    tbl[17] = mk(1, 2'd2, 0, 32'h0,        32'h600,      32'h0,        0, 32'h0,        1, 1, 0);
    tbl[18] = mk(1, 2'd3, 0, 32'h0,        32'h0,        32'h700,      0, 32'h0,        1, 1, 0);
    tbl[19] = mk(1, 2'd2, 0, 32'h0,        32'h800,      32'h0,        0, 32'h0,        1, 1, 0);
    tbl[20] = mk(1, 2'd3, 0, 32'h0,        32'h0,        32'h900,      0, 32'h0,        1, 1, 0);
    tbl[21] = mk(1, 2'd0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h900,      1, 0, 0);
    tbl[22] = mk(1, 2'd3, 0, 32'h0,        32'h0,        32'h5550,     0, 32'h900,      1, 1, 0);
    tbl[23] = mk(0, 2'd0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h80,       0, 0, 0);
    tbl[24] = mk(1, 2'd0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h84,       1, 0, 0);
    tbl[25] = mk(1, 2'd0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h84,       1, 0, 0);

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].rst, tbl[i].src, tbl[i].taken, tbl[i].iaddr, tbl[i].epc,
            tbl[i].trap, tbl[i].ready, 1'b0);
      tick();
      chk($sformatf("row%0d pc", i), pc_out, tbl[i].exp_pc);
      chk($sformatf("row%0d iaddr_out", i), iaddr_out, tbl[i].exp_pc);
      chk($sformatf("row%0d pc_plus_4", i), pc_plus_4_out, tbl[i].exp_pc + 32'd4);
      chk($sformatf("row%0d fetch_valid", i), {31'b0, fetch_valid_out}, {31'b0, tbl[i].exp_fv});
      chk($sformatf("row%0d pending", i), {31'b0, redirect_pending_out}, {31'b0, tbl[i].exp_pend});
      chk($sformatf("row%0d mis_pulse", i), {31'b0, misaligned_instr_logic_out}, {31'b0, tbl[i].exp_mis});
      $display("row %0d: pc=%h fv=%b pend=%b mis=%b", i, pc_out, fetch_valid_out,
               redirect_pending_out, misaligned_instr_logic_out);
    end

    // Hand sequence: combinational candidate, fault address capture, trap recovery.
    drive(1'b1, 2'd1, 1'b1, 32'h2468, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("mux branch candidate", pc_mux_out, 32'h2468);
    tick();
    chk("branch pc", pc_out, 32'h2468);
    chk("branch link", pc_plus_4_out, 32'h246C);
    $display("hand: branch pc=%h", pc_out);

    drive(1'b1, 2'd1, 1'b1, 32'h1236, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("fault pulse", {31'b0, misaligned_instr_logic_out}, 32'd1);
    chk("fault addr", misaligned_addr_out, 32'h1236);
    chk("fault pc held", pc_out, 32'h2468);
    chk("fault fetch_valid", {31'b0, fetch_valid_out}, 32'd0);
    $display("hand: fault addr=%h", misaligned_addr_out);

    drive(1'b1, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("pulse one cycle", {31'b0, misaligned_instr_logic_out}, 32'd0);
    chk("fault addr kept", misaligned_addr_out, 32'h1236);
    chk("fault still held", pc_out, 32'h2468);
    $display("hand: fault hold pc=%h", pc_out);

    drive(1'b1, 2'd3, 1'b0, 32'h0, 32'h0, 32'h40, 1'b0, 1'b0);
    #1;
    chk("mux trap in fault", pc_mux_out, 32'h40);
    tick();
    chk("trap exit pc", pc_out, 32'h40);
    chk("trap exit fetch_valid", {31'b0, fetch_valid_out}, 32'd1);
    $display("hand: trap exit pc=%h", pc_out);
`endif

    // Randomized traffic against the model; first cycle resets both sides.
    for (int i = 0; i < 1500; i++) begin
      logic        r, t, rdy, comp;
      logic [1:0]  s;
      logic [31:0] ia, ep, tr;
      r    = (i == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
      s    = 2'($urandom_range(0, 3));
      t    = 1'($urandom_range(0, 1));
      ia   = $urandom;
      if ($urandom_range(0, 2) != 0) ia[1:0] = 2'b00;
      ep   = $urandom;
      tr   = $urandom;
      rdy  = ($urandom_range(0, 9) < 7);
      comp = 1'($urandom_range(0, 1));
      drive(r, s, t, ia, ep, tr, rdy, comp);
      model_step();
      tick();
      chk("rnd pc", pc_out, m_pc);
      chk("rnd iaddr_out", iaddr_out, m_pc);
      chk("rnd pc_plus_4", pc_plus_4_out, m_pc + 32'd4);
      chk("rnd fetch_valid", {31'b0, fetch_valid_out}, {31'b0, m_fv});
      chk("rnd pending", {31'b0, redirect_pending_out}, {31'b0, (m_q.size() != 0)});
      chk("rnd mis_pulse", {31'b0, misaligned_instr_logic_out}, {31'b0, m_mis});
      chk("rnd mis_addr", misaligned_addr_out, m_maddr);
      $display("rnd %0d: src=%0d rdy=%b pc=%h", i, s, rdy, pc_out);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
Registered next-generation program-counter unit for the RV32I fetch stage. It replaces the combinational next-PC selection with a stateful PC register. It prioritises trap, mret, branch/jump and sequential redirects. It holds the PC while the AHB instruction port is not ready, buffers a redirect that arrives during a stall, and raises a registered instruction-address-misaligned fault, then blocks fetch until the trap redirect arrives.

Parameters:
XLEN, 32, PC and address width
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset

Ports:
clk_in  input  1  clock; all state updates on rising edge
rst_in  input  1  synchronous, active-low reset
pc_src_in  input  2  next-PC source: 00 sequential, 01 branch/jump, 10 mret (epc), 11 trap
branch_taken_in  input  1  qualifies pc_src_in=01; if 0, treated as sequential
iaddr_in  input  XLEN  branch/jump target
epc_in  input  XLEN  mret return address
trap_address_in  input  XLEN  trap vector address
ahb_ready_in  input  1  AHB fetch port ready; 0 = stall
instr_compressed_in  input  1  current instruction is 16-bit (used only with RVC_EN)
pc_out  output  XLEN  registered current fetch PC
iaddr_out  output  XLEN  AHB fetch address; equals pc_out
fetch_valid_out  output  1  fetch request valid
pc_plus_4_out  output  XLEN  pc_out+4, combinational, modulo 2^XLEN (link value)
pc_mux_out  output  XLEN  combinational next-PC candidate
redirect_pending_out  output  1  buffered redirect held (state HOLD)
misaligned_instr_logic_out  output  1  one-cycle registered misaligned-fault pulse
misaligned_addr_out  output  XLEN  faulting target (mtval source)

Behaviour:
- Reset (rst_in=0 at posedge): pc_out=RESET_VECTOR, state RUN, fetch_valid_out=0, redirect_pending_out=0, misaligned_instr_logic_out=0, misaligned_addr_out=0, pending register cleared. fetch_valid_out=1 from the first cycle after release.
- Reset mid-operation overrides everything; a pending redirect or a FAULT is discarded.
- Priority of the candidate: trap(11) > epc(10) > branch (01 & branch_taken_in) > sequential.
- Masking: trap_address_in and epc_in have bits[1:0] forced to 0 (bit0 only with RVC_EN) and are never checked.
- Sequential increment: +4 without RVC_EN. All adds wrap modulo 2^XLEN, so 0xFFFF_FFFC goes to 0x0000_0000.
- Branch target is checked: misaligned if iaddr_in[1:0]!=0 (iaddr_in[0]!=0 with RVC_EN).
- States RUN, HOLD, FAULT.
- RUN, ahb_ready_in=1: pc_out <= pc_mux_out on the next edge.
- RUN, ahb_ready_in=0: pc_out holds. A non-sequential aligned redirect is stored in the pending register with its priority, and the state moves to HOLD.
- HOLD: fetch_valid_out stays 1 at the old PC. A new redirect replaces the pending one only if its priority is greater than or equal to the pending priority; a later trap always wins.
- HOLD, ahb_ready_in=1: pc_out <= merged winner of the pending and same-cycle redirect, then go to RUN. Sequential input does not override the pending redirect.
- Misaligned branch in RUN or HOLD: the target is discarded and pc_out holds. Next cycle misaligned_instr_logic_out=1 for exactly one cycle, misaligned_addr_out=target, and the state moves to FAULT.
- FAULT: fetch_valid_out=0. Only pc_src_in=11 is accepted; it loads pc_out on the next edge regardless of ahb_ready_in, then go to RUN. All other sources are ignored.
- Latency: registered redirect is 1 cycle. pc_mux_out, pc_plus_4_out and iaddr_out are combinational from state/pc_out.

Optional Feature:
RVC_EN:
- Defined: alignment is 2-byte; sequential increment is +2 when instr_compressed_in=1, else +4; epc/trap mask only bit0.
- Undefined: 4-byte alignment; always +4; instr_compressed_in ignored.

Decomposition:
- Package pc_gen_pkg: pc_src encodings (PC_SRC_SEQ/BRANCH/EPC/TRAP), state encodings (ST_RUN/ST_HOLD/ST_FAULT), redirect priority constants.
- Sub-module pc_align_check: combinational misaligned detection and epc/trap masking, RVC_EN-aware.

Test Plan:
- Reset: RESET_VECTOR=0x80, rst_in=0 two cycles -> pc_out=0x80, fetch_valid_out=0; release with ready=1 -> pc_out 0x84, then 0x88.
- Branch: pc_out=0x1000, pc_src=01, branch_taken=1, iaddr=0x2000, ready=1 -> pc_out=0x2000 next cycle, pc_plus_4_out=0x2004.
- Stall buffering: pc_out=0x3000, ready=0, epc_in=0xACBEFC5D -> redirect_pending_out=1. Branch 0x4000 next cycle is ignored. Ready=1 -> pc_out=0xACBEFC5C, pending cleared.
- Misaligned (no RVC): branch to 0x56789ABE -> one-cycle misaligned pulse, misaligned_addr_out=0x56789ABE, fetch_valid_out=0, pc held. Trap 0x11223344 -> pc_out=0x11223344, fetch_valid_out=1. With RVC_EN the same target is accepted.
- Wrap: pc_out=0xFFFFFFFC, sequential, ready=1 -> pc_out=0x00000000.
- Reset in HOLD: pending trap buffered, rst_in=0 -> pc_out=RESET_VECTOR, redirect_pending_out=0, pending redirect never applied.
